// File: rtl/load_store_unit.sv
// RV32I load/store stage: aligns stores onto a word-addressed request/ack bus,
// extracts and extends load data, and flags misaligned, illegal and timed-out accesses.
module load_store_unit #(
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter int unsigned CNT_WIDTH      = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_load,
    input  logic        req_store,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_be,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic        resp_valid,
    output logic [31:0] resp_data,
    output logic [1:0]  resp_err
);

    localparam logic [CNT_WIDTH:0] TMO     = (CNT_WIDTH+1)'(TIMEOUT_CYCLES);
    localparam logic [CNT_WIDTH:0] CNT_ONE = (CNT_WIDTH+1)'(1);

    typedef enum logic [1:0] {IDLE, WAIT_ACK, RESP} state_t;

    state_t               state;
    logic [CNT_WIDTH-1:0] cnt;
    logic [1:0]           off_q;
    logic [2:0]           f3_q;

    logic        illegal_c;
    logic        misaligned_c;
    logic        timeout_c;
    logic [3:0]  be_c;
    logic [31:0] wdata_c;
    logic [31:0] lane_c;
    logic [31:0] ldata_c;

    // Request decode: legality, alignment and lane formatting.
    always_comb begin
        illegal_c    = 1'b0;
        misaligned_c = 1'b0;
        be_c         = 4'b1111;
        wdata_c      = req_wdata;
        if (req_load == req_store)
            illegal_c = 1'b1;
        else if (req_load)
            illegal_c = !(req_funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
        else
            illegal_c = !(req_funct3 inside {3'b000, 3'b001, 3'b010});
        case (req_funct3[1:0])
            2'b00: begin
                be_c    = 4'b0001 << req_addr[1:0];
                wdata_c = {4{req_wdata[7:0]}};
            end
            2'b01: begin
                misaligned_c = req_addr[0];
                be_c         = req_addr[1] ? 4'b1100 : 4'b0011;
                wdata_c      = {2{req_wdata[15:0]}};
            end
            default: misaligned_c = |req_addr[1:0];
        endcase
    end

    // Load lane select and extension from the captured offset/funct3.
    always_comb begin
        lane_c = mem_rdata >> {off_q, 3'b000};
        case (f3_q)
            3'b000:  ldata_c = {{24{lane_c[7]}}, lane_c[7:0]};
            3'b001:  ldata_c = {{16{lane_c[15]}}, lane_c[15:0]};
            3'b100:  ldata_c = {24'd0, lane_c[7:0]};
            3'b101:  ldata_c = {16'd0, lane_c[15:0]};
            default: ldata_c = mem_rdata;
        endcase
    end

    // Timeout fires on the cycle the count would reach the limit; 0 disables it.
    assign timeout_c = (TIMEOUT_CYCLES != 0) && (({1'b0, cnt} + CNT_ONE) == TMO);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            req_ready  <= 1'b1;
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            mem_be     <= '0;
            resp_valid <= 1'b0;
            resp_data  <= '0;
            resp_err   <= 2'b00;
            cnt        <= '0;
            off_q      <= '0;
            f3_q       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        off_q     <= req_addr[1:0];
                        f3_q      <= req_funct3;
                        cnt       <= '0;
                        req_ready <= 1'b0;
                        if (illegal_c || misaligned_c) begin
                            resp_valid <= 1'b1;
                            resp_data  <= '0;
                            resp_err   <= illegal_c ? 2'b10 : 2'b01;
                            state      <= RESP;
                        end else begin
                            mem_req   <= 1'b1;
                            mem_we    <= req_store;
                            mem_addr  <= {req_addr[31:2], 2'b00};
                            mem_wdata <= wdata_c;
                            mem_be    <= be_c;
                            state     <= WAIT_ACK;
                        end
                    end
                end
                WAIT_ACK: begin
                    if (mem_ack) begin
                        mem_req    <= 1'b0;
                        resp_valid <= 1'b1;
                        resp_err   <= 2'b00;
                        resp_data  <= mem_we ? 32'd0 : ldata_c;
                        state      <= RESP;
                    end else if (timeout_c) begin
                        mem_req    <= 1'b0;
                        resp_valid <= 1'b1;
                        resp_err   <= 2'b11;
                        resp_data  <= '0;
                        state      <= RESP;
                    end else begin
                        cnt <= cnt + CNT_WIDTH'(1);
                    end
                end
                RESP: begin
                    resp_valid <= 1'b0;
                    req_ready  <= 1'b1;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed cases plus randomized traffic
// compared against an arithmetic reference model.
module tb_load_store_unit;

    localparam int unsigned TMO = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid, req_ready, req_load, req_store;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr, req_wdata;
    logic        mem_req, mem_we, mem_ack;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_be;
    logic        resp_valid;
    logic [31:0] resp_data;
    logic [1:0]  resp_err;

    int n_vec = 0;
    int n_err = 0;

    load_store_unit #(.TIMEOUT_CYCLES(TMO), .CNT_WIDTH(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_load(req_load), .req_store(req_store),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_be(mem_be),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .resp_valid(resp_valid), .resp_data(resp_data), .resp_err(resp_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference: byte count from funct3 size, lanes and extension by plain arithmetic.
    function automatic void model(input logic ld, input logic st, input logic [2:0] f3,
                                  input logic [31:0] a, input logic [31:0] wd,
                                  input logic [31:0] rd, output logic [1:0] err,
                                  output logic [3:0] be, output logic [31:0] mwd,
                                  output logic [31:0] rdat);
        int nb;
        int off;
        logic [31:0] v;
        off = int'(a[1:0]);
        nb  = 1 << f3[1:0];
        err = 2'd0;
        if (ld == st) err = 2'd2;
        else if (ld && !(f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5})) err = 2'd2;
        else if (st && !(f3 inside {3'd0, 3'd1, 3'd2})) err = 2'd2;
        else if (off % nb != 0) err = 2'd1;
        be  = 4'(((1 << nb) - 1) << off);
        mwd = (nb == 1) ? wd[7:0] * 32'h01010101 :
              (nb == 2) ? wd[15:0] * 32'h00010001 : wd;
        v = rd >> (8 * off);
        if (nb == 1) begin
            v = v & 32'hFF;
            if (!f3[2] && v >= 32'd128) v = v - 32'd256;
        end else if (nb == 2) begin
            v = v & 32'hFFFF;
            if (!f3[2] && v >= 32'd32768) v = v - 32'd65536;
        end
        rdat = (st || err != 2'd0) ? 32'd0 : v;
    endfunction

    // One request; d = no-ack cycles before the ack cycle, d >= TMO means never ack.
    task automatic run_txn(input logic ld, input logic st, input logic [2:0] f3,
                           input logic [31:0] a, input logic [31:0] wd,
                           input logic [31:0] rd, input int d);
        logic [1:0]  e_err;
        logic [3:0]  e_be;
        logic [31:0] e_wd, e_rd;
        int          guard;
        model(ld, st, f3, a, wd, rd, e_err, e_be, e_wd, e_rd);
        guard = 0;
        while (!req_ready && guard < 10) begin
            @(negedge clk);
            guard++;
        end
        check("ready_idle", 32'(req_ready), 32'd1);
        req_valid = 1'b1; req_load = ld; req_store = st;
        req_funct3 = f3; req_addr = a; req_wdata = wd;
        @(negedge clk);
        req_valid = 1'b0;
        req_wdata = $urandom; req_addr = $urandom;
        check("ready_busy", 32'(req_ready), 32'd0);
        if (e_err != 2'd0) begin
            check("err_mem_req", 32'(mem_req), 32'd0);
            check("err_valid", 32'(resp_valid), 32'd1);
            check("err_code", 32'(resp_err), 32'(e_err));
            check("err_data", resp_data, 32'd0);
        end else begin
            check("mem_req", 32'(mem_req), 32'd1);
            check("mem_we", 32'(mem_we), 32'(st));
            check("mem_addr", mem_addr, a & 32'hFFFFFFFC);
            check("mem_be", 32'(mem_be), 32'(e_be));
            if (st) check("mem_wdata", mem_wdata, e_wd);
            for (int i = 0; i < d && i < int'(TMO); i++) begin
                check("wait_req", 32'(mem_req), 32'd1);
                check("wait_resp", 32'(resp_valid), 32'd0);
                mem_rdata = $urandom;
                @(negedge clk);
            end
            if (d < int'(TMO)) begin
                check("ack_req", 32'(mem_req), 32'd1);
                mem_ack = 1'b1; mem_rdata = rd;
                @(negedge clk);
                mem_ack = 1'b0; mem_rdata = $urandom;
                check("ok_code", 32'(resp_err), 32'd0);
                check("ok_data", resp_data, e_rd);
            end else begin
                check("tmo_code", 32'(resp_err), 32'd3);
                check("tmo_data", resp_data, 32'd0);
            end
            check("resp_valid", 32'(resp_valid), 32'd1);
            check("req_dropped", 32'(mem_req), 32'd0);
        end
        @(negedge clk);
        check("resp_pulse", 32'(resp_valid), 32'd0);
        check("ready_back", 32'(req_ready), 32'd1);
    endtask

    initial begin
        rst_n = 1'b0; req_valid = 1'b0; req_load = 1'b0; req_store = 1'b0;
        req_funct3 = 3'd0; req_addr = 32'd0; req_wdata = 32'd0;
        mem_ack = 1'b0; mem_rdata = 32'd0;
        @(negedge clk);
        @(negedge clk);
        check("rst_ready", 32'(req_ready), 32'd1);
        check("rst_mem_req", 32'(mem_req), 32'd0);
        check("rst_we", 32'(mem_we), 32'd0);
        check("rst_addr", mem_addr, 32'd0);
        check("rst_wdata", mem_wdata, 32'd0);
        check("rst_be", 32'(mem_be), 32'd0);
        check("rst_valid", 32'(resp_valid), 32'd0);
        check("rst_data", resp_data, 32'd0);
        check("rst_err", 32'(resp_err), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // SB byte-lane replication at offset 3
        run_txn(1'b0, 1'b1, 3'b000, 32'h1003, 32'h000000A5, 32'h0, 1);
        check("sb_be_last", 32'(mem_be), 32'h8);
        check("sb_wdata_last", mem_wdata, 32'hA5A5A5A5);
        // LB / LBU / LHU extraction
        run_txn(1'b1, 1'b0, 3'b000, 32'h2001, 32'h0, 32'h123480FF, 0);
        run_txn(1'b1, 1'b0, 3'b100, 32'h2001, 32'h0, 32'h123480FF, 2);
        run_txn(1'b1, 1'b0, 3'b101, 32'h2002, 32'h0, 32'h123480FF, 1);
        // Misaligned, both-flag illegal, bad funct3
        run_txn(1'b1, 1'b0, 3'b010, 32'h3002, 32'h0, 32'h0, 0);
        run_txn(1'b1, 1'b1, 3'b010, 32'h3000, 32'h0, 32'h0, 0);
        run_txn(1'b1, 1'b0, 3'b011, 32'h3000, 32'h0, 32'h0, 0);
        run_txn(1'b0, 1'b0, 3'b010, 32'h3001, 32'h0, 32'h0, 0);
        // Timeout, then ack landing on the timeout cycle
        run_txn(1'b1, 1'b0, 3'b010, 32'h4000, 32'h0, 32'hDEADBEEF, int'(TMO));
        run_txn(1'b1, 1'b0, 3'b010, 32'h4000, 32'h0, 32'hDEADBEEF, int'(TMO) - 1);
        // Back-to-back SW then LW
        run_txn(1'b0, 1'b1, 3'b010, 32'h5000, 32'hCAFEF00D, 32'h0, 0);
        run_txn(1'b1, 1'b0, 3'b010, 32'h5004, 32'h0, 32'h87654321, 3);

        // Reset while waiting for ack, then a stale ack
        req_valid = 1'b1; req_load = 1'b1; req_store = 1'b0;
        req_funct3 = 3'b010; req_addr = 32'h6000;
        @(negedge clk);
        req_valid = 1'b0;
        check("pre_rst_req", 32'(mem_req), 32'd1);
        rst_n = 1'b0;
        #1;
        check("async_rst_req", 32'(mem_req), 32'd0);
        check("async_rst_ready", 32'(req_ready), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        mem_ack = 1'b1; mem_rdata = 32'h11111111;
        @(negedge clk);
        mem_ack = 1'b0;
        check("stale_valid", 32'(resp_valid), 32'd0);
        check("stale_req", 32'(mem_req), 32'd0);
        check("stale_ready", 32'(req_ready), 32'd1);
        @(negedge clk);
        check("stale_valid2", 32'(resp_valid), 32'd0);

        // Randomized traffic
        for (int n = 0; n < 200; n++) begin
            logic ld, st;
            logic [2:0] f3;
            int r, d;
            r  = int'($urandom_range(0, 19));
            ld = (r < 9) || (r == 19);
            st = (r >= 9 && r < 18) || (r == 19);
            f3 = ($urandom_range(0, 3) == 0) ? 3'($urandom) :
                 (ld ? 3'($urandom_range(0, 2)) | (3'($urandom_range(0, 1)) << 2)
                     : 3'($urandom_range(0, 2)));
            d  = ($urandom_range(0, 9) == 0) ? int'(TMO) : int'($urandom_range(0, 3));
            run_txn(ld, st, f3, $urandom, $urandom, $urandom, d);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
